// File: rtl/mem_port_responder_pkg.sv
// Types and default widths shared by the memory port responder and the CPU datapath.
package mem_port_responder_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mp_state_t;

endpackage

// File: rtl/mem_word_array.sv
// Single-port word storage: the write and the registered read both happen on the clock edge.
module mem_word_array
  import mem_port_responder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_port_responder.sv
// Memory-side responder for the CPU's unified memory port: one request at a time,
// fixed wait states, then a valid/ready response.
module mem_port_responder
  import mem_port_responder_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_ifetch,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_ifetch,
  output logic              rsp_err,
  output logic              busy,
  output logic [CNT_W-1:0]  access_cnt
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WCNT_W = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [WCNT_W-1:0] WAIT_L  = WCNT_W'(WAIT_CYC);

  mp_state_t         state;
  logic [WCNT_W-1:0] wait_cnt;
  logic              lat_we;
  logic              lat_ifetch;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              rd_hit;
  logic [DATA_W-1:0] ram_q;
  logic              accept;
  logic              commit;
  logic              in_range;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign commit    = (state == ACCESS) && (wait_cnt == '0);
  assign in_range  = {1'b0, lat_addr} < DEPTH_L;

  // Array output is only exposed after an in-range read; stores, errors and reset show zero.
  assign rsp_rdata = rd_hit ? ram_q : '0;

  mem_word_array #(
    .DATA_W(DATA_W),
    .ADDR_W(IDX_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (commit & in_range & lat_we),
    .re   (commit & in_range & ~lat_we),
    .addr (lat_addr[IDX_W-1:0]),
    .wdata(lat_wdata),
    .rdata(ram_q)
  );

  // Request fields are captured once at acceptance; later bus activity is ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we     <= req_we;
      lat_ifetch <= req_ifetch;
      lat_addr   <= req_addr;
      lat_wdata  <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      rsp_valid  <= 1'b0;
      rsp_ifetch <= 1'b0;
      rsp_err    <= 1'b0;
      rd_hit     <= 1'b0;
      busy       <= 1'b0;
      access_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state    <= ACCESS;
            busy     <= 1'b1;
            wait_cnt <= WAIT_L;
          end
        end
        ACCESS: begin
          if (wait_cnt == '0) begin
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_err    <= ~in_range;
            rsp_ifetch <= lat_ifetch;
            rd_hit     <= in_range & ~lat_we;
          end else begin
            wait_cnt <= wait_cnt - WCNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            if (access_cnt != '1) access_cnt <= access_cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
